// File: rtl/vpu_dma_pkg.sv
// vpu_dma_pkg: shared constants for the vpu_dma_wr bus-master DMA writer.
// Holds the FSM state encoding, the register address map and the
// ctrl/status bit positions.
package vpu_dma_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SETUP  = 3'd3;
    localparam logic [2:0] ST_STROBE = 3'd4;
    localparam logic [2:0] ST_RECOV  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_REL    = 3'd7;

    // Register window addresses
    localparam logic [3:0] REG_PTR_HI  = 4'h0;
    localparam logic [3:0] REG_PTR_LO  = 4'h1;
    localparam logic [3:0] REG_DATA    = 4'h2;
    localparam logic [3:0] REG_CTRL    = 4'h3;
    localparam logic [3:0] REG_ADDR_HI = 4'h4;
    localparam logic [3:0] REG_ADDR_LO = 4'h5;
    localparam logic [3:0] REG_STEP    = 4'h6;
    localparam logic [3:0] REG_LEN     = 4'h7;
    localparam logic [3:0] REG_START   = 4'h8;
    localparam logic [3:0] REG_FILL    = 4'h9;

    // Ctrl/status bit positions in register $3
    localparam int CTRL_IRQ  = 7;
    localparam int CTRL_IEN  = 6;
    localparam int CTRL_BSY  = 5;
    localparam int CTRL_ERR  = 4;
    localparam int CTRL_FILL = 3;

endpackage

// File: rtl/vpu_dma_wr_if.sv
// vpu_dma_wr_if: external-memory write bus driven by the DMA writer.
// master = the DMA engine, slave = memory / bus observer.
interface vpu_dma_wr_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] MADDR;
    logic [7:0]        MDOUT;
    logic              memcs;
    logic              memwe;
    logic              hold;

    modport master (
        output MADDR,
        output MDOUT,
        output memcs,
        output memwe,
        output hold
    );

    modport slave (
        input MADDR,
        input MDOUT,
        input memcs,
        input memwe,
        input hold
    );
endinterface

// File: rtl/vpu_dma_buf.sv
// vpu_dma_buf: 2**BUF_AW x 8 local buffer. One synchronous write port
// (CPU), asynchronous read ports for CPU readback and for the DMA engine.
// A same-cycle write and DMA read of one index returns the old byte.
module vpu_dma_buf #(
    parameter int BUF_AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [BUF_AW-1:0] cpu_raddr,
    output logic [7:0]        cpu_rdata,
    input  logic [BUF_AW-1:0] dma_raddr,
    output logic [7:0]        dma_rdata
);
    logic [7:0] mem [2**BUF_AW];

    // CPU write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign cpu_rdata = mem[cpu_raddr];
    assign dma_rdata = mem[dma_raddr];
endmodule

// File: rtl/vpu_dma_wr.sv
// vpu_dma_wr: bus-master DMA writer. CPU loads a local buffer through a
// register window, programs address/step/length, and a $7 write starts a
// held-bus sequence of strobed byte writes ending in an interrupt.
// Optional feature macro: VPU_DMA_WR_FILL_EN (constant fill value source).
module vpu_dma_wr
    import vpu_dma_pkg::*;
#(
    parameter int BUF_AW = 6,
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   AD,
    input  logic [7:0]   DI,
    output logic [7:0]   DO,
    input  logic         rw,
    input  logic         cs,
    output logic         irq,
    vpu_dma_wr_if.master mem
);
    logic [2:0]        state_q, state_d;
    logic [BUF_AW-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        step_q, step_d;
    logic [7:0]        len_q, len_d;
    logic [BUF_AW-1:0] start_q, start_d;
    logic [BUF_AW-1:0] idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              irq_flag_q, irq_flag_d;
    logic              ien_q, ien_d;
    logic              err_q, err_d;
    logic [7:0]        do_q, do_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        mdout_q, mdout_d;
    logic              memcs_q, memcs_d;
    logic              memwe_q, memwe_d;
    logic              hold_q, hold_d;

    logic              reg_wr, reg_rd, bsy, cfg_wr, buf_we;
    logic [7:0]        buf_cpu_rd, buf_dma_rd, rd_mux, status;
    logic [BUF_AW-1:0] dma_idx;
    logic              fill_on;
    logic [7:0]        fill_val;

`ifdef VPU_DMA_WR_FILL_EN
    logic              fill_q, fill_d;
    logic [7:0]        fillv_q, fillv_d;
    assign fill_on  = fill_q;
    assign fill_val = fillv_q;
`else
    assign fill_on  = 1'b0;
    assign fill_val = 8'h00;
`endif

    assign reg_wr = cs & ~rw;
    assign reg_rd = cs & rw;
    assign bsy    = (state_q != ST_IDLE);
    assign cfg_wr = reg_wr && (AD >= REG_ADDR_HI) && (AD <= REG_START);
    assign buf_we = reg_wr && (AD == REG_DATA);

    // Engine reads the index it will present in SETUP: advanced when leaving RECOV
    assign dma_idx = (state_q == ST_RECOV && !fill_on) ? idx_q + BUF_AW'(1) : idx_q;

    vpu_dma_buf #(.BUF_AW(BUF_AW)) u_buf (
        .clk       (clk),
        .we        (buf_we),
        .waddr     (ptr_q),
        .wdata     (DI),
        .cpu_raddr (ptr_q),
        .cpu_rdata (buf_cpu_rd),
        .dma_raddr (dma_idx),
        .dma_rdata (buf_dma_rd)
    );

    // CPU read data selection
    always_comb begin
        status            = 8'h00;
        status[CTRL_IRQ]  = irq_flag_q;
        status[CTRL_IEN]  = ien_q;
        status[CTRL_BSY]  = bsy;
        status[CTRL_ERR]  = err_q;
        status[CTRL_FILL] = fill_on;
        case (AD)
            REG_PTR_HI:  rd_mux = 8'h00;
            REG_PTR_LO:  rd_mux = 8'(ptr_q);
            REG_DATA:    rd_mux = buf_cpu_rd;
            REG_CTRL:    rd_mux = status;
            REG_ADDR_HI: rd_mux = 8'(addr_q >> 8);
            REG_ADDR_LO: rd_mux = addr_q[7:0];
            REG_STEP:    rd_mux = step_q;
            REG_LEN:     rd_mux = len_q;
            REG_START:   rd_mux = 8'(start_q);
            REG_FILL:    rd_mux = fill_val;
            default:     rd_mux = 8'h00;
        endcase
    end

    // Register window, FSM sequencing and bus output next-state
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        step_d     = step_q;
        len_d      = len_q;
        start_d    = start_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        irq_flag_d = irq_flag_q;
        ien_d      = ien_q;
        err_d      = err_q;
        do_d       = do_q;
        maddr_d    = maddr_q;
        mdout_d    = mdout_q;
`ifdef VPU_DMA_WR_FILL_EN
        fill_d     = fill_q;
        fillv_d    = fillv_q;
`endif

        // Status read clears sticky bits first so a same-cycle set wins
        if (reg_rd) begin
            do_d = rd_mux;
            if (AD == REG_CTRL) begin
                irq_flag_d = 1'b0;
                err_d      = 1'b0;
            end
        end

        if (reg_wr) begin
            case (AD)
                REG_PTR_LO:  ptr_d = DI[BUF_AW-1:0];
                REG_DATA:    ptr_d = ptr_q + BUF_AW'(1);
                REG_CTRL: begin
                    ien_d = DI[CTRL_IEN];
`ifdef VPU_DMA_WR_FILL_EN
                    fill_d = DI[CTRL_FILL];
`endif
                end
                REG_ADDR_HI: if (!bsy) addr_d = ADDR_W'({DI, addr_q[7:0]});
                REG_ADDR_LO: if (!bsy) addr_d = ADDR_W'({addr_q[ADDR_W-1:8], DI});
                REG_STEP:    if (!bsy) step_d = DI;
                REG_START:   if (!bsy) start_d = DI[BUF_AW-1:0];
                REG_LEN: begin
                    if (!bsy) begin
                        len_d = DI;
                        if (DI == 8'h00) begin
                            irq_flag_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                            cnt_d   = 8'h00;
                            idx_d   = start_q;
                        end
                    end
                end
`ifdef VPU_DMA_WR_FILL_EN
                REG_FILL:    fillv_d = DI;
`endif
                default: ;
            endcase
            if (cfg_wr && bsy) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_REQ:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_RECOV;
            ST_RECOV: begin
                addr_d  = addr_q + ADDR_W'(step_q);
                idx_d   = dma_idx;
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q + 8'd1 == len_q) ? ST_DONE : ST_SETUP;
            end
            ST_DONE:   state_d = ST_REL;
            ST_REL: begin
                irq_flag_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: ;
        endcase

        hold_d  = (state_d != ST_IDLE);
        memcs_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_RECOV);
        memwe_d = (state_d == ST_STROBE);
        // Address and data latch on SETUP entry and hold through RECOV
        if (state_d == ST_SETUP) begin
            maddr_d = addr_d;
            mdout_d = fill_on ? fill_val : buf_dma_rd;
        end
    end

    // State and register flops; reset drops every bus output at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            step_q     <= 8'd1;
            len_q      <= 8'd0;
            start_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= 8'd0;
            irq_flag_q <= 1'b0;
            ien_q      <= 1'b0;
            err_q      <= 1'b0;
            do_q       <= 8'd0;
            maddr_q    <= '0;
            mdout_q    <= 8'd0;
            memcs_q    <= 1'b0;
            memwe_q    <= 1'b0;
            hold_q     <= 1'b0;
`ifdef VPU_DMA_WR_FILL_EN
            fill_q     <= 1'b0;
            fillv_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            step_q     <= step_d;
            len_q      <= len_d;
            start_q    <= start_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            irq_flag_q <= irq_flag_d;
            ien_q      <= ien_d;
            err_q      <= err_d;
            do_q       <= do_d;
            maddr_q    <= maddr_d;
            mdout_q    <= mdout_d;
            memcs_q    <= memcs_d;
            memwe_q    <= memwe_d;
            hold_q     <= hold_d;
`ifdef VPU_DMA_WR_FILL_EN
            fill_q     <= fill_d;
            fillv_q    <= fillv_d;
`endif
        end
    end

    assign DO        = do_q;
    assign irq       = irq_flag_q & ien_q;
    assign mem.MADDR = maddr_q;
    assign mem.MDOUT = mdout_q;
    assign mem.memcs = memcs_q;
    assign mem.memwe = memwe_q;
    assign mem.hold  = hold_q;
endmodule

// File: tb/tb_vpu_dma_wr.sv
// tb_vpu_dma_wr: scoreboard bench for vpu_dma_wr. Stimulus pushes expected
// memory writes and CPU read data into queues; monitors pop and compare
// whenever the DUT strobes memwe or returns registered read data.
module tb_vpu_dma_wr;
    logic       clk;
    logic       rst;
    logic [3:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;

    vpu_dma_wr_if #(.ADDR_W(16)) mem_if ();

    vpu_dma_wr #(.BUF_AW(6), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs),
        .irq (irq),
        .mem (mem_if)
    );

    int          checks = 0;
    int          errors = 0;
    int          hold_cnt = 0;
    logic [23:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic        rd_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: external memory write strobes
    always @(negedge clk) begin
        if (rst && mem_if.memwe) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         mem_if.MADDR, mem_if.MDOUT);
            end else begin
                logic [23:0] e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_if.MADDR), 32'(e[23:8]));
                chk("wr_data", 32'(mem_if.MDOUT), 32'(e[7:0]));
                chk("wr_memcs", 32'(mem_if.memcs), 32'd1);
            end
        end
    end

    // Monitor: registered CPU read data
    always @(posedge clk) rd_seen <= cs && rw && rst;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected none", DO);
            end else begin
                logic [7:0] e;
                e = rd_q.pop_front();
                chk("cpu_read", 32'(DO), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        if (mem_if.hold) hold_cnt++;
    end

    task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic reg_rd(input logic [3:0] a, input logic [7:0] exp);
        cs = 1'b1; rw = 1'b1; AD = a;
        rd_q.push_back(exp);
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(irq), 32'd1);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 4'h0; DI = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_DO", 32'(DO), 32'h0);
        chk("rst_hold", 32'(mem_if.hold), 32'h0);
        chk("rst_memcs", 32'(mem_if.memcs), 32'h0);
        chk("rst_memwe", 32'(mem_if.memwe), 32'h0);
        chk("rst_MADDR", 32'(mem_if.MADDR), 32'h0);
        chk("rst_MDOUT", 32'(mem_if.MDOUT), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        reg_rd(4'h6, 8'h01);
        reg_rd(4'h3, 8'h00);
        reg_rd(4'hA, 8'h00);

        // Basic fill of three bytes
        reg_wr(4'h1, 8'h00);
        reg_wr(4'h2, 8'h11);
        reg_wr(4'h2, 8'h22);
        reg_wr(4'h2, 8'h33);
        reg_wr(4'h4, 8'h40);
        reg_wr(4'h5, 8'h00);
        reg_wr(4'h6, 8'h01);
        reg_wr(4'h3, 8'h40);
        wr_q.push_back({16'h4000, 8'h11});
        wr_q.push_back({16'h4001, 8'h22});
        wr_q.push_back({16'h4002, 8'h33});
        hold_cnt = 0;
        reg_wr(4'h7, 8'h03);
        chk("hold_rise", 32'(mem_if.hold), 32'd1);
        wait_irq("fill_irq");
        chk("fill_hold_cycles", 32'(hold_cnt), 32'd13);
        reg_rd(4'h3, 8'hC0);
        chk("fill_irq_cleared", 32'(irq), 32'd0);
        reg_wr(4'h1, 8'h01);
        reg_rd(4'h2, 8'h22);
        reg_rd(4'h1, 8'h01);
        reg_rd(4'h0, 8'h00);

        // Step 2 across the address wrap, buffer index wraps 63 -> 0
        reg_wr(4'h1, 8'h3F);
        reg_wr(4'h2, 8'h5A);
        reg_wr(4'h2, 8'hA5);
        reg_rd(4'h1, 8'h01);
        reg_wr(4'h8, 8'h3F);
        reg_wr(4'h4, 8'hFF);
        reg_wr(4'h5, 8'hFE);
        reg_wr(4'h6, 8'h02);
        wr_q.push_back({16'hFFFE, 8'h5A});
        wr_q.push_back({16'h0000, 8'hA5});
        reg_wr(4'h7, 8'h02);
        wait_irq("wrap_irq");
        reg_rd(4'h3, 8'hC0);
        reg_rd(4'h4, 8'h00);
        reg_rd(4'h5, 8'h02);
        reg_rd(4'h8, 8'h3F);

        // Zero length: immediate IRQ, no bus activity
        hold_cnt = 0;
        reg_wr(4'h7, 8'h00);
        chk("zero_irq", 32'(irq), 32'd1);
        reg_rd(4'h3, 8'hC0);
        chk("zero_irq_cleared", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        chk("zero_no_hold", 32'(hold_cnt), 32'd0);

        // Busy protection
        reg_wr(4'h1, 8'h00);
        reg_wr(4'h2, 8'h01);
        reg_wr(4'h2, 8'h02);
        reg_wr(4'h2, 8'h03);
        reg_wr(4'h2, 8'h04);
        reg_wr(4'h8, 8'h00);
        reg_wr(4'h4, 8'h20);
        reg_wr(4'h5, 8'h00);
        reg_wr(4'h6, 8'h01);
        wr_q.push_back({16'h2000, 8'h01});
        wr_q.push_back({16'h2001, 8'h02});
        wr_q.push_back({16'h2002, 8'h03});
        wr_q.push_back({16'h2003, 8'h04});
        reg_wr(4'h7, 8'h04);
        reg_wr(4'h4, 8'h12);
        reg_wr(4'h7, 8'h09);
        reg_rd(4'h3, 8'h70);
        wait_irq("busy_irq");
        reg_rd(4'h3, 8'hC0);
        reg_rd(4'h7, 8'h04);
        reg_rd(4'h4, 8'h20);
        reg_rd(4'h5, 8'h04);

        // Reset during STROBE
        reg_wr(4'h4, 8'h30);
        reg_wr(4'h5, 8'h00);
        wr_q.push_back({16'h3000, 8'h01});
        reg_wr(4'h7, 8'h02);
        begin
            int n = 0;
            while (!mem_if.memwe && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_strobe_seen", 32'(mem_if.memwe), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_memwe", 32'(mem_if.memwe), 32'd0);
        chk("async_memcs", 32'(mem_if.memcs), 32'd0);
        chk("async_hold", 32'(mem_if.hold), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        hold_cnt = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_no_hold", 32'(hold_cnt), 32'd0);
        reg_rd(4'h6, 8'h01);
        reg_rd(4'h3, 8'h00);
        reg_rd(4'h4, 8'h00);
        reg_rd(4'h7, 8'h00);

`ifdef VPU_DMA_WR_FILL_EN
        // Constant fill source
        reg_wr(4'h9, 8'hAA);
        reg_wr(4'h3, 8'h48);
        reg_wr(4'h4, 8'h80);
        reg_wr(4'h5, 8'h00);
        wr_q.push_back({16'h8000, 8'hAA});
        wr_q.push_back({16'h8001, 8'hAA});
        wr_q.push_back({16'h8002, 8'hAA});
        wr_q.push_back({16'h8003, 8'hAA});
        reg_wr(4'h7, 8'h04);
        wait_irq("fill_mode_irq");
        reg_rd(4'h3, 8'hC8);
        reg_rd(4'h9, 8'hAA);
`else
        // Fill feature absent: bit 3 and $9 read as zero
        reg_wr(4'h9, 8'hAA);
        reg_wr(4'h3, 8'h48);
        reg_rd(4'h3, 8'h40);
        reg_rd(4'h9, 8'h00);
`endif

        repeat (3) @(negedge clk);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vpu_dma_wr.md
Name: vpu_dma_wr

Overview:
- Bus-master DMA writer: moves a block of bytes from a 64-byte local buffer out to external memory.
- The CPU fills the buffer through a register window, programs the target address, step and length, then the engine takes the bus (hold), performs strobed byte writes and raises an interrupt on completion.
- Sits beside the video DMA reader on the same external-memory port.

Parameters:
- BUF_AW, 6, log2 of local buffer depth (64 bytes)
- ADDR_W, 16, external address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- AD  in  4  register address
- DI  in  8  CPU write data
- DO  out  8  CPU read data (registered)
- rw  in  1  1=read, 0=write
- cs  in  1  register select, one access per cycle while high
- irq  out  1  interrupt = IRQ & IEN
- MADDR  out  16  external memory address
- MDOUT  out  8  external write data
- memcs  out  1  external memory select
- memwe  out  1  external write strobe
- hold  out  1  bus request/ownership, CPU halted while high

Behaviour:
- Register map:
  - $0/$1 buffer pointer hi/lo (RW; bits [BUF_AW-1:0] used, hi reads 0)
  - $2 data port: write stores DI at the pointer then pointer+1; read returns the buffer byte at the pointer, no increment
  - $3 ctrl/status IRQ|IEN|BSY|ERR|0000: IEN RW; IRQ, BSY, ERR R-; a read clears IRQ and ERR
  - $4/$5 ext address hi/lo (RW)
  - $6 step (RW, reset 1)
  - $7 length (RW); a write starts the transfer
  - $8 buffer start index (RW, reset 0)
  - others read 0
- Reset: DO=0, MADDR=0, MDOUT=0, memcs=0, memwe=0, hold=0, irq=0; all registers 0 except step=1; FSM IDLE.
- FSM:
  - IDLE -> REQ on a $7 write with DI≠0; DI=0 sets IRQ immediately, no bus activity.
  - REQ: hold=1 -> SETTLE.
  - SETTLE: one idle cycle -> SETUP.
  - SETUP: memcs=1, MADDR=addr, MDOUT=buf[idx] -> STROBE.
  - STROBE: memwe=1 -> RECOV.
  - RECOV: memwe=0; addr+=step, idx+=1, cnt+=1; if cnt==len -> DONE, else SETUP.
  - DONE: memcs=0 -> REL.
  - REL: hold=0, IRQ=1, BSY=0 -> IDLE.
- Timing: hold rises 1 cycle after the $7 write and falls 3*len+4 cycles after it. MADDR and MDOUT are stable for all of SETUP..RECOV.
- Arithmetic:
  - External address adds step zero-extended, mod 2^16, so 0xFFFF+1 -> 0x0000.
  - Buffer index wraps mod 64.
  - len is 8-bit, max 255, so buffer bytes repeat cyclically.
- While BSY:
  - Writes to $4-$8 and $7 are ignored and set ERR.
  - $0-$2 and $3 (IEN) stay accessible; $2 writes during a transfer land in the buffer.
  - Simultaneous $2 write and DMA read of the same index: the DMA gets the old byte.
- Simultaneous IRQ set (REL) and $3 read in the same cycle: DO shows IRQ=0, and IRQ ends up 1 (set wins).
- Reset mid-transfer: all bus outputs drop asynchronously; the partial transfer is abandoned and no IRQ is raised.

Optional Feature:
- VPU_DMA_WR_FILL_EN
- Defined:
  - $3 bit 3 becomes FILL (RW).
  - With FILL=1, every byte written is register $9 (fill value, RW, reset 0), and the buffer index does not advance.
  - Timing is identical.
- Undefined:
  - $3 bit 3 reads 0.
  - $9 reads 0 and ignores writes.
  - The buffer is always the source.

Decomposition:
- Package vpu_dma_pkg:
  - FSM state enum (IDLE, REQ, SETTLE, SETUP, STROBE, RECOV, DONE, REL)
  - register address constants $0-$9
  - ctrl bit indices
- Sub-module vpu_dma_buf: 64x8 simple dual-port RAM, synchronous write, asynchronous read, write port for the CPU, read port for the engine.

Test Plan:
- Fill: ptr=0, write $2 with 0x11,0x22,0x33; addr=0x4000, step=1, len=3 -> writes 0x11@0x4000, 0x22@0x4001, 0x33@0x4002. hold is high for exactly 13 cycles. IRQ=1 and irq=1 with IEN set.
- Step and wrap: addr=0xFFFE, step=2, len=2 -> writes at 0xFFFE and 0x0000. With start index 63, bytes come from buffer 63 then 0.
- Zero length: len=0 -> hold never rises, IRQ=1 next cycle. A $3 read returns 0xC0 (IEN=1) and clears IRQ.
- Busy protection: writing $4=0x12 mid-transfer leaves the address unchanged and sets ERR. A second $7 write is ignored; the transfer count is unchanged.
- Reset: rst low during STROBE -> memwe, memcs and hold are 0 in the same cycle, no IRQ; after reset, step reads 1.
- With VPU_DMA_WR_FILL_EN defined: $9=0xAA, FILL=1, len=4, addr=0x8000 -> 0xAA written at 0x8000..0x8003, buffer index unchanged.
